fb_pixel_writer: RTL and testbench



---
 rtl/fb_pixel_writer.sv | 128 ++++++++++++
 tb/tb_fb_pixel_writer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_pixel_writer.sv
`default_nettype none
// fb_pixel_writer: buffers plot requests in a small FIFO, clips them to the screen,
// writes one pixel per cycle into the framebuffer and runs full-screen clears.
module fb_pixel_writer #(
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int COLOUR_W   = 9,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                plot,
  input  logic [7:0]          x,
  input  logic [7:0]          y,
  input  logic [COLOUR_W-1:0] colour,
  output logic                ready,
  input  logic                clear_req,
  input  logic [COLOUR_W-1:0] clear_colour,
  output logic                clear_busy,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [COLOUR_W-1:0] mem_data,
  output logic                mem_we,
  output logic [7:0]          clip_count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t state, state_next;

  logic [7:0]          fifo_x [FIFO_DEPTH];
  logic [7:0]          fifo_y [FIFO_DEPTH];
  logic [COLOUR_W-1:0] fifo_c [FIFO_DEPTH];
  logic [PTR_W:0]      wr_ptr, rd_ptr, occupancy;
  logic [PTR_W-1:0]    wr_idx, rd_idx;
  logic                fifo_empty, fifo_full;
  logic                in_range, accept, push, pop, drain_done;
  logic [ADDR_W-1:0]   clear_cnt, head_addr;
  logic [COLOUR_W-1:0] clear_col;

  // Extra pointer bit distinguishes full from empty.
  assign occupancy  = wr_ptr - rd_ptr;
  assign fifo_empty = (occupancy == '0);
  assign fifo_full  = (occupancy == (PTR_W+1)'(FIFO_DEPTH));
  assign wr_idx     = wr_ptr[PTR_W-1:0];
  assign rd_idx     = rd_ptr[PTR_W-1:0];

  assign in_range = (int'(x) < SCREEN_W) && (int'(y) < SCREEN_H);
  assign ready    = resetn && (state == RUN) && !fifo_full && !clear_req;
  assign accept   = plot && ready;
  assign push     = accept && in_range;
  assign pop      = ((state == RUN) || (state == DRAIN)) && !fifo_empty;

  // Nothing is pushed outside RUN, so the drain ends once the last entry pops.
  assign drain_done = (occupancy == {{PTR_W{1'b0}}, pop});

  assign head_addr = ADDR_W'(fifo_y[rd_idx]) * ADDR_W'(SCREEN_W) + ADDR_W'(fifo_x[rd_idx]);

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (clear_req) state_next = DRAIN;
      DRAIN:   if (drain_done) state_next = CLEAR;
      CLEAR:   if (clear_cnt == LAST_ADDR) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_x[wr_idx] <= x;
      fifo_y[wr_idx] <= y;
      fifo_c[wr_idx] <= colour;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= RUN;
      clear_busy <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      clear_cnt  <= '0;
      clear_col  <= '0;
      clip_count <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
    end else begin
      state      <= state_next;
      clear_busy <= (state_next != RUN);

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      if (accept && !in_range && clip_count != 8'hFF)
        clip_count <= clip_count + 8'd1;

      if (state == RUN && clear_req)
        clear_col <= clear_colour;

      if (state == DRAIN)
        clear_cnt <= '0;
      else if (state == CLEAR)
        clear_cnt <= clear_cnt + 1'b1;

      if (pop) begin
        mem_we   <= 1'b1;
        mem_addr <= head_addr;
        mem_data <= fifo_c[rd_idx];
      end else if (state == CLEAR) begin
        mem_we   <= 1'b1;
        mem_addr <= clear_cnt;
        mem_data <= clear_col;
      end else begin
        mem_we <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fb_pixel_writer.sv
`default_nettype none
// tb_fb_pixel_writer: table vectors, hand-written clear/reset sequences and random
// plots, all cross-checked every cycle against a queue-based reference model.
module tb_fb_pixel_writer;
  logic        clk = 1'b0;
  logic        resetn, plot, clear_req;
  logic [7:0]  x, y;
  logic [8:0]  colour, clear_colour;
  logic        ready, clear_busy, mem_we;
  logic [14:0] mem_addr;
  logic [8:0]  mem_data;
  logic [7:0]  clip_count;

  always #5 clk = ~clk;

  fb_pixel_writer dut (
    .clk(clk), .resetn(resetn), .plot(plot), .x(x), .y(y), .colour(colour),
    .ready(ready), .clear_req(clear_req), .clear_colour(clear_colour),
    .clear_busy(clear_busy), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_we(mem_we), .clip_count(clip_count)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int addr;
    int data;
  } pix_t;

  localparam int M_RUN = 0, M_DRAIN = 1, M_CLEAR = 2;

  pix_t m_q[$];
  pix_t wlog[$];
  int   m_mode, m_clip, m_ccnt, m_ccol, m_we, m_addr, m_data, m_busy;

  typedef struct {
    logic [7:0]  x, y;
    logic [8:0]  colour;
    logic        exp_we;
    logic [14:0] exp_addr;
    logic [8:0]  exp_data;
    logic [7:0]  exp_clip;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_ready();
    return (resetn && m_mode == M_RUN && m_q.size() < 4 && !clear_req) ? 1 : 0;
  endfunction

  task automatic model_edge();
    int   rdy;
    pix_t p;
    rdy = model_ready();
    if (!resetn) begin
      m_q.delete();
      m_mode = M_RUN; m_clip = 0; m_ccol = 0; m_ccnt = 0;
      m_we = 0; m_addr = 0; m_data = 0;
    end else begin
      m_we = 0;
      if (m_mode != M_CLEAR && m_q.size() > 0) begin
        p = m_q.pop_front();
        m_we = 1; m_addr = p.addr; m_data = p.data;
      end else if (m_mode == M_CLEAR) begin
        m_we = 1; m_addr = m_ccnt; m_data = m_ccol;
      end
      if (plot && rdy != 0) begin
        if (x >= 160 || y >= 120) begin
          if (m_clip < 255) m_clip++;
        end else begin
          m_q.push_back('{int'(y) * 160 + int'(x), int'(colour)});
        end
      end
      case (m_mode)
        M_RUN:   if (clear_req) begin m_mode = M_DRAIN; m_ccol = int'(clear_colour); end
        M_DRAIN: if (m_q.size() == 0) begin m_mode = M_CLEAR; m_ccnt = 0; end
        default: if (m_ccnt == 19199) m_mode = M_RUN; else m_ccnt++;
      endcase
    end
    m_busy = (m_mode != M_RUN) ? 1 : 0;
  endtask

  // One clock: ready checked mid-cycle, registered outputs checked just after the edge.
  task automatic step();
    @(negedge clk);
    chk("ready", ready, model_ready());
    @(posedge clk);
    model_edge();
    #1;
    chk("mem_we", mem_we, m_we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_data", mem_data, m_data);
    chk("clear_busy", clear_busy, m_busy);
    chk("clip_count", clip_count, m_clip);
    if (mem_we === 1'b1) wlog.push_back('{int'(mem_addr), int'(mem_data)});
  endtask

  task automatic wait_clear_done(input string name);
    for (int n = 0; n < 20000 && clear_busy === 1'b1; n++) step();
    chk(name, clear_busy, 0);
  endtask

  initial begin
    int px[3], py[3], pc[3];
    int bad;

    vecs[0] = '{8'd10,  8'd5,   9'h1FF, 1'b1, 15'd810,   9'h1FF, 8'd0};
    vecs[1] = '{8'd160, 8'd0,   9'h001, 1'b0, 15'd0,     9'h000, 8'd1};
    vecs[2] = '{8'd0,   8'd120, 9'h002, 1'b0, 15'd0,     9'h000, 8'd2};
    vecs[3] = '{8'd159, 8'd119, 9'h005, 1'b1, 15'd19199, 9'h005, 8'd2};
    vecs[4] = '{8'd0,   8'd0,   9'h003, 1'b1, 15'd0,     9'h003, 8'd2};
    vecs[5] = '{8'd255, 8'd255, 9'h007, 1'b0, 15'd0,     9'h000, 8'd3};
    vecs[6] = '{8'd0,   8'd119, 9'h100, 1'b1, 15'd19040, 9'h100, 8'd3};

    resetn = 1'b0; plot = 1'b1; x = 8'd1; y = 8'd1; colour = 9'd1;
    clear_req = 1'b0; clear_colour = 9'd0;
    m_mode = M_RUN; m_clip = 0; m_ccnt = 0; m_ccol = 0;
    m_we = 0; m_addr = 0; m_data = 0; m_busy = 0;

    // Reset state
    step(); step();
    chk("rst_ready", ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_clip", clip_count, 0);
    resetn = 1'b1; plot = 1'b0;
    step();

    // Table: one plot, then the cycle where its write appears
    foreach (vecs[i]) begin
      plot = 1'b1; x = vecs[i].x; y = vecs[i].y; colour = vecs[i].colour;
      step();
      plot = 1'b0;
      step();
      chk("vec_we", mem_we, vecs[i].exp_we);
      if (vecs[i].exp_we) begin
        chk("vec_addr", mem_addr, vecs[i].exp_addr);
        chk("vec_data", mem_data, vecs[i].exp_data);
      end
      chk("vec_clip", clip_count, vecs[i].exp_clip);
      step();
      chk("vec_we_single", mem_we, 0);
    end

    // Back-to-back burst along the diagonal
    wlog.delete();
    for (int i = 0; i < 8; i++) begin
      plot = 1'b1; x = 8'(i); y = 8'(i); colour = 9'(i);
      #1 chk("burst_ready", ready, 1);
      step();
    end
    plot = 1'b0;
    step(); step();
    chk("burst_count", wlog.size(), 8);
    for (int i = 0; i < 8 && i < wlog.size(); i++) begin
      chk("burst_addr", wlog[i].addr, 161 * i);
      chk("burst_data", wlog[i].data, i);
    end

    // Random plots with occasional resets
    for (int n = 0; n < 1500; n++) begin
      resetn = ($urandom_range(0, 199) != 0);
      plot   = ($urandom_range(0, 9) < 6);
      x      = 8'($urandom_range(0, 175));
      y      = 8'($urandom_range(0, 130));
      colour = 9'($urandom);
      step();
    end
    resetn = 1'b1; plot = 1'b0;
    step(); step();

    // Clip counter saturation
    for (int n = 0; n < 300; n++) begin
      plot = 1'b1; x = 8'd200; y = 8'($urandom_range(0, 255));
      step();
    end
    plot = 1'b0;
    step();
    chk("clip_saturated", clip_count, 255);

    // Three pixels, then a clear
    px = '{1, 3, 159}; py = '{2, 4, 119}; pc = '{'h11, 'h22, 'h33};
    wlog.delete();
    for (int i = 0; i < 3; i++) begin
      plot = 1'b1; x = 8'(px[i]); y = 8'(py[i]); colour = 9'(pc[i]);
      step();
    end
    plot = 1'b0; clear_req = 1'b1; clear_colour = 9'h049;
    step();
    clear_req = 1'b0;
    chk("clr_busy_start", clear_busy, 1);
    wait_clear_done("clr_done");
    chk("clr_total", wlog.size(), 3 + 19200);
    for (int i = 0; i < 3 && i < wlog.size(); i++) begin
      chk("clr_pix_addr", wlog[i].addr, py[i] * 160 + px[i]);
      chk("clr_pix_data", wlog[i].data, pc[i]);
    end
    bad = 0;
    for (int i = 0; i < 19200; i++)
      if (i + 3 >= wlog.size() || wlog[i+3].addr != i || wlog[i+3].data != 'h049) bad++;
    chk("clr_seq_bad", bad, 0);
    chk("clr_ready_after", ready, 1);

    // Plot together with clear_req, then a second clear_req mid-clear
    wlog.delete();
    plot = 1'b1; x = 8'd7; y = 8'd7; colour = 9'd1;
    clear_req = 1'b1; clear_colour = 9'h155;
    #1 chk("plot_vs_clear_ready", ready, 0);
    step();
    plot = 1'b0; clear_req = 1'b0;
    for (int n = 0; n < 200; n++) step();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    wait_clear_done("clr2_done");
    chk("clr2_total", wlog.size(), 19200);
    bad = 0;
    for (int i = 0; i < wlog.size(); i++)
      if (wlog[i].addr != i || wlog[i].data != 'h155) bad++;
    chk("clr2_seq_bad", bad, 0);

    // Reset when the clear counter reaches 500
    wlog.delete();
    clear_req = 1'b1; clear_colour = 9'h0AA;
    step();
    clear_req = 1'b0;
    for (int n = 0; n < 2000 && wlog.size() < 500; n++) step();
    chk("pre_reset_writes", wlog.size(), 500);
    resetn = 1'b0;
    step();
    chk("abort_we", mem_we, 0);
    chk("abort_busy", clear_busy, 0);
    chk("abort_addr", mem_addr, 0);
    resetn = 1'b1;
    #1 chk("abort_ready", ready, 1);
    for (int n = 0; n < 20; n++) step();
    chk("abort_no_writes", wlog.size(), 500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
